// File: rtl/bit_timer_ctrl.sv
// Serial-receive bit timing sequencer: align / data / stop phases with shift and done strobes.
// Optional stop-bit check (serial_in, framing_error) is built when STOP_BIT_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// ALIGN | counting half a bit period to reach the bit centre
// DATA  | one shift_strobe per bit period, N times
// STOP  | one more bit period, then packet_done
module bit_timer_ctrl #(
  parameter int CNT_BITS  = 4,
  parameter int NBIT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_BITS-1:0]  bit_period,
  input  logic [NBIT_BITS-1:0] num_bits,
`ifdef STOP_BIT_CHECK_EN
  input  logic                 serial_in,
`endif
  output logic                 shift_strobe,
  output logic                 packet_done,
  output logic                 busy
`ifdef STOP_BIT_CHECK_EN
  ,
  output logic                 framing_error
`endif
);

  typedef enum logic [1:0] {IDLE, ALIGN, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  tmr_q, tmr_d;
  logic [NBIT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0]  p_q, p_d;
  logic [NBIT_BITS-1:0] n_q, n_d;
  logic                 shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_BITS-1:0]  pc, h, pc_m1;

  // Strobes are decided one cycle early (at Pc-1) so they can leave a flop exactly at Pc.
  always_comb begin
    pc    = (p_q < CNT_BITS'(2)) ? CNT_BITS'(2) : p_q;
    h     = pc >> 1;
    pc_m1 = pc - CNT_BITS'(1);
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    p_d       = p_q;
    n_d       = n_q;
    shift_d   = 1'b0;
    done_d    = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      tmr_d     = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d   = ALIGN;
            tmr_d     = CNT_BITS'(1);
            bit_cnt_d = '0;
            p_d       = bit_period;
            n_d       = num_bits;
          end
        end
        ALIGN: begin
          if (tmr_q == h) begin
            state_d = (n_q == '0) ? STOP : DATA;
            tmr_d   = CNT_BITS'(1);
          end else begin
            tmr_d = tmr_q + CNT_BITS'(1);
          end
        end
        DATA: begin
          shift_d = (tmr_q == pc_m1);
          if (tmr_q == pc) begin
            tmr_d     = CNT_BITS'(1);
            bit_cnt_d = bit_cnt_q + NBIT_BITS'(1);
            if (bit_cnt_q == (n_q - NBIT_BITS'(1))) state_d = STOP;
          end else begin
            tmr_d = tmr_q + CNT_BITS'(1);
          end
        end
        STOP: begin
          done_d = (tmr_q == pc_m1);
          if (tmr_q == pc) begin
            state_d   = IDLE;
            tmr_d     = '0;
            bit_cnt_d = '0;
          end else begin
            tmr_d = tmr_q + CNT_BITS'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          tmr_d     = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      p_q       <= '0;
      n_q       <= '0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      p_q       <= p_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign shift_strobe = shift_q;
  assign packet_done  = done_q;
  assign busy         = busy_q;

`ifdef STOP_BIT_CHECK_EN
  logic fe_q, fe_d;

  // The stop bit is sampled in the packet_done cycle: STOP with the timer at Pc.
  always_comb begin
    fe_d = fe_q;
    if (abort && (state_q != IDLE)) begin
      fe_d = 1'b0;
    end else if ((state_q == IDLE) && start) begin
      fe_d = 1'b0;
    end else if ((state_q == STOP) && (tmr_q == pc)) begin
      fe_d = !serial_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) fe_q <= 1'b0;
    else        fe_q <= fe_d;
  end

  assign framing_error = fe_q;
`endif

endmodule
